// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types, access-size codes and alignment helper for mips_bus_master
package mips_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_INSTR,
        RD_DATA,
        WR_DATA,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Reserved size code 3 is reported as misaligned so it never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = low[0];
            SZ_WORD: is_misaligned = (low != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/bus_lane_align.sv
// rtl/bus_lane_align.sv - combinational byte-lane enables, store replication and load extraction
import mips_bus_pkg::*;

module bus_lane_align #(
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8,
    parameter int LANE_W = $clog2(BE_W)
) (
    input  logic [1:0]        size,
    input  logic [LANE_W-1:0] lane,
    input  logic              signed_load,
    input  logic [31:0]       store_data,
    input  logic [DATA_W-1:0] readdata,
    output logic [BE_W-1:0]   byteenable,
    output logic [DATA_W-1:0] writedata,
    output logic [31:0]       load_data
);

    logic [DATA_W-1:0] shifted;

    assign shifted = readdata >> {lane, 3'b000};

    always_comb begin
        byteenable = '0;
        writedata  = '0;
        load_data  = '0;
        case (size)
            SZ_BYTE: begin
                byteenable = BE_W'(1) << lane;
                writedata  = {BE_W{store_data[7:0]}};
                load_data  = {{24{signed_load & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                byteenable = BE_W'(3) << lane;
                writedata  = {(BE_W/2){store_data[15:0]}};
                load_data  = {{16{signed_load & shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                byteenable = BE_W'(4'hF) << lane;
                writedata  = {(BE_W/4){store_data}};
                load_data  = shifted[31:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_bus_master.sv
// rtl/mips_bus_master.sv - Avalon-MM master arbitrating MIPS fetch and load/store; MIPS_BUS_TIMEOUT_EN adds a waitrequest timeout
import mips_bus_pkg::*;

module mips_bus_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ifetch_req,
    input  logic [ADDR_W-1:0]   ifetch_addr,
    output logic                ifetch_ack,
    output logic [31:0]         ifetch_data,
    output logic                ifetch_err,
    input  logic                dreq,
    input  logic                dwe,
    input  logic [1:0]          dsize,
    input  logic                dsigned,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic [31:0]         dwdata,
    output logic                dack,
    output logic [31:0]         drdata,
    output logic                derr,
    output logic                busy,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);

    state_t              state, state_n;
    logic                req_fetch, req_we, req_signed, req_err;
    logic                req_fetch_n, req_we_n, req_signed_n, req_err_n;
    logic [1:0]          req_size, req_size_n;
    logic [LANE_W-1:0]   req_lane, req_lane_n;

    logic [ADDR_W-1:0]   address_n;
    logic                read_n, write_n, busy_n;
    logic [DATA_W-1:0]   writedata_n;
    logic [BE_W-1:0]     byteenable_n;
    logic                ifetch_ack_n, ifetch_err_n, dack_n, derr_n;
    logic [31:0]         ifetch_data_n, drdata_n;

    logic                finish, finish_err, timed_out;
    logic [31:0]         finish_data;

    logic [1:0]          in_size;
    logic [ADDR_W-1:0]   in_addr;
    logic                in_mis;
    logic [1:0]          al_size;
    logic [LANE_W-1:0]   al_lane;
    logic [BE_W-1:0]     al_byteenable;
    logic [DATA_W-1:0]   al_writedata;
    logic [31:0]         al_load;

    assign in_size = dreq ? dsize : SZ_WORD;
    assign in_addr = dreq ? daddr : ifetch_addr;
    assign in_mis  = is_misaligned(in_size, in_addr[1:0]);

    // The lane helper serves the incoming request while idle and the captured one afterwards.
    assign al_size = (state == IDLE) ? in_size : req_size;
    assign al_lane = (state == IDLE) ? in_addr[LANE_W-1:0] : req_lane;

    bus_lane_align #(.DATA_W(DATA_W)) u_align (
        .size        (al_size),
        .lane        (al_lane),
        .signed_load (req_signed),
        .store_data  (dwdata),
        .readdata    (readdata),
        .byteenable  (al_byteenable),
        .writedata   (al_writedata),
        .load_data   (al_load)
    );

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if ((state != RESP) && waitrequest) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = waitrequest && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_n       = state;
        req_fetch_n   = req_fetch;
        req_we_n      = req_we;
        req_signed_n  = req_signed;
        req_err_n     = req_err;
        req_size_n    = req_size;
        req_lane_n    = req_lane;
        address_n     = address;
        read_n        = read;
        write_n       = write;
        writedata_n   = writedata;
        byteenable_n  = byteenable;
        ifetch_ack_n  = 1'b0;
        ifetch_err_n  = 1'b0;
        ifetch_data_n = '0;
        dack_n        = 1'b0;
        derr_n        = 1'b0;
        drdata_n      = '0;
        finish        = 1'b0;
        finish_err    = 1'b0;
        finish_data   = '0;

        case (state)
            IDLE: begin
                if (dreq || ifetch_req) begin
                    req_fetch_n  = !dreq;
                    req_we_n     = dreq && dwe;
                    req_signed_n = dreq && dsigned;
                    req_size_n   = in_size;
                    req_lane_n   = in_addr[LANE_W-1:0];
                    req_err_n    = in_mis;
                    state_n      = !dreq ? RD_INSTR : (dwe ? WR_DATA : RD_DATA);
                    // A misaligned request still spends one quiet cycle here so its ack lands in cycle 2.
                    if (!in_mis) begin
                        address_n    = {in_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                        read_n       = !(dreq && dwe);
                        write_n      = dreq && dwe;
                        writedata_n  = al_writedata;
                        byteenable_n = al_byteenable;
                    end
                end
            end
            RD_INSTR, RD_DATA, WR_DATA: begin
                if (req_err) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (!waitrequest) begin
                    finish      = 1'b1;
                    finish_data = req_we ? 32'd0 : al_load;
                end else if (timed_out) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (finish) begin
            state_n = RESP;
            read_n  = 1'b0;
            write_n = 1'b0;
            if (req_fetch) begin
                ifetch_ack_n  = 1'b1;
                ifetch_err_n  = finish_err;
                ifetch_data_n = finish_data;
            end else begin
                dack_n   = 1'b1;
                derr_n   = finish_err;
                drdata_n = finish_data;
            end
        end
    end

    assign busy_n = (state_n != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_fetch   <= 1'b0;
            req_we      <= 1'b0;
            req_signed  <= 1'b0;
            req_err     <= 1'b0;
            req_size    <= SZ_WORD;
            req_lane    <= '0;
            address     <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            writedata   <= '0;
            byteenable  <= '0;
            ifetch_ack  <= 1'b0;
            ifetch_err  <= 1'b0;
            ifetch_data <= '0;
            dack        <= 1'b0;
            derr        <= 1'b0;
            drdata      <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            req_fetch   <= req_fetch_n;
            req_we      <= req_we_n;
            req_signed  <= req_signed_n;
            req_err     <= req_err_n;
            req_size    <= req_size_n;
            req_lane    <= req_lane_n;
            address     <= address_n;
            read        <= read_n;
            write       <= write_n;
            writedata   <= writedata_n;
            byteenable  <= byteenable_n;
            ifetch_ack  <= ifetch_ack_n;
            ifetch_err  <= ifetch_err_n;
            ifetch_data <= ifetch_data_n;
            dack        <= dack_n;
            derr        <= derr_n;
            drdata      <= drdata_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_mips_bus_master.sv
// tb/tb_mips_bus_master.sv - scoreboard bench for mips_bus_master (32-bit and 64-bit bus instances)
`timescale 1ns/1ps
import mips_bus_pkg::*;

module tb_mips_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ifetch_req = 0, dreq = 0, dwe = 0, dsigned = 0, waitrequest = 0;
    logic [31:0] ifetch_addr = 0, daddr = 0, dwdata = 0, readdata = 0;
    logic [1:0]  dsize = 0;
    logic        ifetch_ack, ifetch_err, dack, derr, busy, read, write;
    logic [31:0] ifetch_data, drdata, address, writedata;
    logic [3:0]  byteenable;

    logic        d64_req = 0;
    logic [31:0] d64_addr = 0;
    logic [63:0] d64_readdata = 0;
    logic        d64_fack, d64_ferr, d64_dack, d64_derr, d64_busy, d64_read, d64_write;
    logic [31:0] d64_fdata, d64_drdata, d64_address;
    logic [63:0] d64_writedata;
    logic [7:0]  d64_be;

    always #5 clk = ~clk;

    mips_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) u_dut (
        .clk(clk), .reset(reset),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
        .ifetch_ack(ifetch_ack), .ifetch_data(ifetch_data), .ifetch_err(ifetch_err),
        .dreq(dreq), .dwe(dwe), .dsize(dsize), .dsigned(dsigned), .daddr(daddr), .dwdata(dwdata),
        .dack(dack), .drdata(drdata), .derr(derr), .busy(busy),
        .address(address), .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    mips_bus_master #(.ADDR_W(32), .DATA_W(64)) u_dut64 (
        .clk(clk), .reset(reset),
        .ifetch_req(1'b0), .ifetch_addr(32'd0),
        .ifetch_ack(d64_fack), .ifetch_data(d64_fdata), .ifetch_err(d64_ferr),
        .dreq(d64_req), .dwe(1'b0), .dsize(SZ_WORD), .dsigned(1'b0), .daddr(d64_addr), .dwdata(32'd0),
        .dack(d64_dack), .drdata(d64_drdata), .derr(d64_derr), .busy(d64_busy),
        .address(d64_address), .read(d64_read), .write(d64_write), .writedata(d64_writedata), .byteenable(d64_be),
        .waitrequest(1'b0), .readdata(d64_readdata)
    );

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          fetch;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (read && write) check("rw_exclusive", 1, 0);
            if (dack || ifetch_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_kind", ifetch_ack, e.fetch);
                    check("ack_data", e.fetch ? ifetch_data : drdata, e.data);
                    check("ack_err",  e.fetch ? ifetch_err  : derr,   e.err);
                end
            end
        end
    end

    task automatic run(input bit dv, input bit fv, input bit we, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] fa, input logic [31:0] wd,
                       input logic [31:0] rd, input int nwait, input bit eerr, input bit ferr,
                       input logic [31:0] edata, input logic [31:0] fdata, input bit chk_bus,
                       input logic [3:0] ebe, input logic [31:0] eaddr, input logic [31:0] ewd,
                       input int erc, input int dlat, input int flat, input string tag);
        int  cyc = 0, rc = 0, w = 0;
        bit  dgot = !dv, fgot = !fv, bus_seen = 0;
        @(negedge clk);
        dreq = dv; dwe = we; dsize = sz; dsigned = sg; daddr = a; dwdata = wd;
        ifetch_req = fv; ifetch_addr = fa; readdata = rd; waitrequest = 0;
        if (dv) sb.push_back('{fetch: 1'b0, data: edata, err: eerr});
        if (fv) sb.push_back('{fetch: 1'b1, data: fdata, err: ferr});
        while (!(dgot && fgot) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (read || write) begin
                rc++;
                if (chk_bus && !bus_seen) begin
                    bus_seen = 1;
                    check({tag, "_be"}, byteenable, ebe);
                    check({tag, "_addr"}, address, eaddr);
                    check({tag, "_dir"}, {read, write}, we ? 2'b01 : 2'b10);
                    if (we) check({tag, "_wdata"}, writedata, ewd);
                end
                waitrequest = (w < nwait);
                w++;
            end else begin
                waitrequest = 0;
            end
            if (dack) begin dgot = 1; check({tag, "_dlat"}, cyc, dlat); dreq = 0; end
            if (ifetch_ack) begin fgot = 1; check({tag, "_flat"}, cyc, flat); ifetch_req = 0; end
        end
        if (!(dgot && fgot)) check({tag, "_ack_timeout"}, 0, 1);
        check({tag, "_bus_cycles"}, rc, erc);
        waitrequest = 0;
        @(negedge clk);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int acks;
        repeat (2) @(negedge clk);
        check("rst_bus", {address, writedata, byteenable, read, write}, 0);
        check("rst_flags", {ifetch_ack, ifetch_err, dack, derr, busy}, 0);
        check("rst_data", {ifetch_data, drdata}, 0);
        reset = 1;

        run(0,1,0,SZ_WORD,0, 32'h0, 32'h40, 0, 32'h24020005, 0, 0,0, 0, 32'h24020005, 1, 4'hF, 32'h40, 0, 1, 0, 2, "fetch");
        run(1,0,0,SZ_BYTE,1, 32'h103, 0, 0, 32'h80FFFFFF, 3, 0,0, 32'hFFFFFF80, 0, 1, 4'b1000, 32'h100, 0, 4, 5, 0, "lb");
        run(1,0,0,SZ_BYTE,0, 32'h103, 0, 0, 32'h80FFFFFF, 3, 0,0, 32'h00000080, 0, 1, 4'b1000, 32'h100, 0, 4, 5, 0, "lbu");
        run(1,0,1,SZ_HALF,0, 32'h202, 0, 32'h0000ABCD, 0, 1, 0,0, 0, 0, 1, 4'b1100, 32'h200, 32'hABCDABCD, 2, 3, 0, "sh");
        run(1,1,0,SZ_WORD,0, 32'h300, 32'h44, 0, 32'h11223344, 0, 0,0, 32'h11223344, 32'h11223344, 0, 0, 0, 0, 2, 2, 5, "arb");
        run(1,0,0,SZ_WORD,0, 32'h101, 0, 0, 32'hFFFFFFFF, 0, 1,0, 0, 0, 0, 0, 0, 0, 0, 2, 0, "lw_mis");
        run(1,0,0,SZ_HALF,1, 32'h205, 0, 0, 32'hFFFFFFFF, 0, 1,0, 0, 0, 0, 0, 0, 0, 0, 2, 0, "lh_mis");
        run(1,0,1,2'd3,0,    32'h200, 0, 32'h12345678, 0, 0, 1,0, 0, 0, 0, 0, 0, 0, 0, 2, 0, "sz3");
        run(1,0,0,SZ_HALF,1, 32'h102, 0, 0, 32'h80011234, 0, 0,0, 32'hFFFF8001, 0, 1, 4'b1100, 32'h100, 0, 1, 2, 0, "lh");
        run(1,0,1,SZ_BYTE,0, 32'h101, 0, 32'h0000005A, 0, 0, 0,0, 0, 0, 1, 4'b0010, 32'h100, 32'h5A5A5A5A, 1, 2, 0, "sb");
        run(1,0,1,SZ_WORD,0, 32'h10, 0, 32'hDEADBEEF, 0, 2, 0,0, 0, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 3, 4, 0, "sw");
        run(0,1,0,SZ_WORD,0, 32'h0, 32'h42, 0, 32'h24020005, 0, 0,1, 0, 0, 0, 0, 0, 0, 0, 0, 2, "fetch_mis");
        run(1,0,0,SZ_HALF,0, 32'h200, 0, 0, 32'h1234F00D, 0, 0,0, 32'h0000F00D, 0, 1, 4'b0011, 32'h200, 0, 1, 2, 0, "lhu");
        run(1,0,0,SZ_HALF,1, 32'h200, 0, 0, 32'h1234F00D, 0, 0,0, 32'hFFFFF00D, 0, 1, 4'b0011, 32'h200, 0, 1, 2, 0, "lh0");
`ifdef MIPS_BUS_TIMEOUT_EN
        run(1,0,0,SZ_WORD,0, 32'h500, 0, 0, 32'h12345678, 100, 1,0, 0, 0, 1, 4'hF, 32'h500, 0, 4, 5, 0, "timeout");
`endif

        // Reset while stalled on waitrequest must drop read at once and never ack.
        @(negedge clk);
        dreq = 1; dwe = 0; dsize = SZ_WORD; daddr = 32'h400; waitrequest = 1;
        @(negedge clk);
        check("rst_mid_read_before", read, 1);
        reset = 0;
        #1;
        check("rst_mid_read", read, 0);
        check("rst_mid_busy", busy, 0);
        dreq = 0; waitrequest = 0;
        @(negedge clk);
        reset = 1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (dack || ifetch_ack) acks++;
        end
        check("rst_mid_no_ack", acks, 0);

        @(negedge clk);
        d64_req = 1; d64_addr = 32'h104; d64_readdata = 64'hCAFEBABE_01234567;
        @(negedge clk);
        check("w64_read", d64_read, 1);
        check("w64_be", d64_be, 8'hF0);
        check("w64_addr", d64_address, 32'h100);
        @(negedge clk);
        check("w64_dack", d64_dack, 1);
        check("w64_data", d64_drdata, 32'hCAFEBABE);
        d64_req = 0;
        @(negedge clk);
        check("w64_idle", d64_busy, 0);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
